// File: rtl/spi_master_gen.sv
// SPI master, modes 0-3, programmable SCLK half-period of div+1 clk cycles; MSB first by default.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first port selecting LSB-first shifting per transfer.
module spi_master_gen #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi
);

    localparam int HC_W = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              half_end, enter_half, smp, shf, lsb_in;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    assign half_end = (cnt_q == div_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        hcnt_d     = hcnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        enter_half = 1'b0;
        smp        = 1'b0;
        shf        = 1'b0;
        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                cnt_d  = '0;
                if (start) begin
                    state_d = S_LEAD;
                    div_d   = div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_in;
                    tx_d    = tx_data;
                end
            end
            S_LEAD: begin
                if (half_end) begin
                    cnt_d      = '0;
                    hcnt_d     = '0;
                    state_d    = S_SHIFT;
                    enter_half = 1'b1;
                    sclk_d     = ~sclk_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_SHIFT: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (hcnt_q == HC_LAST) begin
                        state_d = S_TRAIL;
                    end else begin
                        hcnt_d     = hcnt_q + HC_W'(1);
                        enter_half = 1'b1;
                        sclk_d     = ~sclk_q;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_TRAIL: begin
                if (half_end) begin
                    cnt_d     = '0;
                    state_d   = S_DONE;
                    rx_data_d = rx_q;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Even halves open with a leading edge, odd halves with a trailing edge.
        // In mode cpha=1 the first leading edge keeps bit 0, already on mosi since LEAD.
        if (enter_half) begin
            smp = cpha_q ? hcnt_d[0] : ~hcnt_d[0];
            shf = cpha_q ? (~hcnt_d[0] && (hcnt_d != '0)) : hcnt_d[0];
        end
        if (smp) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end
        if (shf) begin
            tx_d = lsb_q ? (tx_q >> 1) : (tx_q << 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            hcnt_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
        end
    end

    assign busy    = (state_q == S_LEAD) || (state_q == S_SHIFT) || (state_q == S_TRAIL);
    assign cs_n    = ~busy;
    assign done    = (state_q == S_DONE);
    assign sclk    = sclk_q;
    assign rx_data = rx_data_q;
    assign mosi    = busy ? (lsb_q ? tx_q[0] : tx_q[DATA_W-1]) : 1'b0;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: timing, all SPI modes, back-to-back, ignored starts, reset abort.
module tb_spi_master_gen;

    localparam int DW = 8;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst_n, cpol, cpha, start, miso;
    logic [VW-1:0] div;
    logic [DW-1:0] tx_data, rx_data;
    logic          busy, done, cs_n, sclk, mosi;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic          lsb_first;
`endif

    int total = 0;
    int bad = 0;
    int cyc_g = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    spi_master_gen #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .div       (div),
        .cpol      (cpol),
        .cpha      (cpha),
        .start     (start),
        .tx_data   (tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .miso      (miso),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi)
    );

    // Slave: either loops mosi straight back, or shifts out s_word in mode-0 timing.
    logic       s_loop = 1'b0;
    logic       s_lsb = 1'b0;
    logic [7:0] s_word = 8'h00;
    int         sidx = 0;
    logic       s_bit;

    always @(negedge cs_n) sidx = 0;
    always @(sclk) if (!cs_n && sclk == cpol) sidx = sidx + 1;
    always @* begin
        int bi;
        bi = s_lsb ? sidx : 7 - sidx;
        s_bit = (bi >= 0 && bi < 8) ? s_word[bi] : 1'b0;
    end
    assign miso = s_loop ? mosi : s_bit;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_g++;
        if (done) done_cnt++;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input logic [7:0] tx, input logic [7:0] dv, input logic pol,
                           input logic pha, input bit disturb, output int cyc,
                           output logic [7:0] mbits, output int hi_cnt, output int hi_max);
        int   run;
        logic prev;
        tx_data = tx; div = dv; cpol = pol; cpha = pha; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; mbits = '0; hi_cnt = 0; hi_max = 0; run = 0; prev = sclk;
        while (!done && cyc < 6000) begin
            if (sclk != prev && sclk != pol) mbits = {mbits[6:0], mosi};
            if (sclk) begin
                hi_cnt++;
                run++;
                if (run > hi_max) hi_max = run;
            end else begin
                run = 0;
            end
            prev = sclk;
            if (disturb) begin
                start = (cyc == 3 || cyc == 10 || cyc == 40);
                if (cyc == 20) begin
                    tx_data = 8'hFF; div = '0; cpol = ~pol; cpha = ~pha;
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0; tx_data = tx; div = dv; cpol = pol; cpha = pha;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, hc, hm, dc0, n, cs_hi, d1, d2;
        logic [7:0] mb;
        logic [1:0] md;

        rst_n = 1'b0; start = 1'b0; div = 8'd4; cpol = 1'b0; cpha = 1'b0; tx_data = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        tick();
        tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cs_n", cs_n, 1);
        check_val("rst_sclk", sclk, 0);
        check_val("rst_mosi", mosi, 0);
        check_val("rst_rx", rx_data, 0);
        rst_n = 1'b1;
        tick();

        // Mode 0, div=4: 0x69 out, slave answers 0x27.
        s_word = 8'h27; s_loop = 1'b0;
        dc0 = done_cnt;
        do_xfer(8'h69, 8'd4, 1'b0, 1'b0, 1'b0, cyc, mb, hc, hm);
        check_val("m0_cycles", cyc, 90);
        check_val("m0_mosi_bits", mb, 8'h69);
        check_val("m0_rx", rx_data, 8'h27);
        check_val("m0_sclk_hi_total", hc, 40);
        check_val("m0_sclk_hi_run", hm, 5);
        check_val("m0_done_busy", busy, 0);
        check_val("m0_done_cs_n", cs_n, 1);
        check_val("m0_done_count", done_cnt - dc0, 1);
        tick();
        check_val("m0_done_single", done, 0);
        check_val("m0_rx_hold", rx_data, 8'h27);

        // Idle sclk follows cpol one cycle later.
        cpol = 1'b1;
        check_val("idle_sclk_no_comb", sclk, 0);
        tick();
        check_val("idle_sclk_follow_hi", sclk, 1);
        cpol = 1'b0;
        tick();
        check_val("idle_sclk_follow_lo", sclk, 0);

        // All four modes, loopback, div=1 -> 2*18 cycles.
        s_loop = 1'b1;
        for (int m = 0; m < 4; m++) begin
            md = 2'(m);
            cpol = md[1];
            tick();
            check_val($sformatf("mode%0d_idle_pre", m), sclk, md[1]);
            do_xfer(8'hA5, 8'd1, md[1], md[0], 1'b0, cyc, mb, hc, hm);
            check_val($sformatf("mode%0d_cycles", m), cyc, 36);
            check_val($sformatf("mode%0d_rx", m), rx_data, 8'hA5);
            tick();
            check_val($sformatf("mode%0d_idle_post", m), sclk, md[1]);
        end
        cpol = 1'b0;
        tick();

        // Maximum divider: half-period of 256 cycles.
        do_xfer(8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, cyc, mb, hc, hm);
        check_val("divmax_cycles", cyc, 256 * 18);
        check_val("divmax_rx", rx_data, 8'h5A);
        tick();

        // Back-to-back at div=0, start held through DONE: done-to-done = 18 busy + DONE + one IDLE.
        tx_data = 8'h01; div = '0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        check_val("b2b_first_cycles", n, 18);
        check_val("b2b_first_rx", rx_data, 8'h01);
        d1 = cyc_g;
        tx_data = 8'hFE;
        cs_hi = 0; n = 0;
        do begin
            tick();
            n++;
            if (cs_n) cs_hi++;
        end while (!busy && n < 100);
        start = 1'b0;
        check_val("b2b_cs_n_gap", cs_hi, 1);
        while (!done && n < 200) begin tick(); n++; end
        d2 = cyc_g;
        check_val("b2b_done_spacing", d2 - d1, 20);
        check_val("b2b_second_rx", rx_data, 8'hFE);
        tick();

        // Starts and config changes while busy must not disturb the transfer.
        dc0 = done_cnt;
        do_xfer(8'h3C, 8'd4, 1'b0, 1'b0, 1'b1, cyc, mb, hc, hm);
        check_val("ign_cycles", cyc, 90);
        check_val("ign_rx", rx_data, 8'h3C);
        repeat (100) tick();
        check_val("ign_done_count", done_cnt - dc0, 1);
        check_val("ign_idle_busy", busy, 0);

        // Reset at cycle 30 of a transfer aborts it.
        cpol = 1'b1;
        tick();
        tx_data = 8'h81; div = 8'd4; cpha = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        check_val("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        dc0 = done_cnt;
        tick();
        check_val("abort_cs_n", cs_n, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_sclk", sclk, 0);
        check_val("abort_rx", rx_data, 0);
        check_val("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (120) tick();
        check_val("abort_no_done", done_cnt - dc0, 0);
        cpol = 1'b0;
        tick();

`ifdef SPI_MASTER_LSB_FIRST_EN
        s_loop = 1'b0; s_lsb = 1'b1; s_word = 8'h27; lsb_first = 1'b1;
        do_xfer(8'h69, 8'd4, 1'b0, 1'b0, 1'b0, cyc, mb, hc, hm);
        check_val("lsb_mosi_bits", mb, 8'h96);
        check_val("lsb_rx", rx_data, 8'h27);
        lsb_first = 1'b0; s_lsb = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
